// File: rtl/redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : redirect_ctrl_if
//  Brief    : CSR-unit / fetch facing signal bundle of the redirect controller.
//             The master side is the pipeline/CSR/fetch environment, the
//             slave side is redirect_ctrl itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface redirect_ctrl_if;
   logic        s_valid_i;
   logic        s_stall_i;
   logic        s_flush_i;
   logic        s_rstpp_req_i;
   logic        s_exception_i;
   logic        s_treturn_i;
   logic        s_int_pending_i;
   logic        s_hrdmax_en_i;
   logic [31:0] s_rst_point_i;
   logic [31:0] s_exc_trap_i;
   logic [31:0] s_int_trap_i;
   logic [31:0] s_mepc_i;
   logic        s_fetch_ready_i;
   logic        s_redirect_o;
   logic [31:0] s_redirect_add_o;
   logic        s_interrupted_o;
   logic        s_rstpp_o;
   logic        s_hrdmax_o;
   logic        s_busy_o;

   modport master (
      output s_valid_i, s_stall_i, s_flush_i, s_rstpp_req_i, s_exception_i,
             s_treturn_i, s_int_pending_i, s_hrdmax_en_i, s_rst_point_i,
             s_exc_trap_i, s_int_trap_i, s_mepc_i, s_fetch_ready_i,
      input  s_redirect_o, s_redirect_add_o, s_interrupted_o, s_rstpp_o,
             s_hrdmax_o, s_busy_o
   );

   modport slave (
      input  s_valid_i, s_stall_i, s_flush_i, s_rstpp_req_i, s_exception_i,
             s_treturn_i, s_int_pending_i, s_hrdmax_en_i, s_rst_point_i,
             s_exc_trap_i, s_int_trap_i, s_mepc_i, s_fetch_ready_i,
      output s_redirect_o, s_redirect_add_o, s_interrupted_o, s_rstpp_o,
             s_hrdmax_o, s_busy_o
   );
endinterface
`default_nettype wire

// File: rtl/redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : redirect_ctrl
//  Brief    : Arbitrates restart / exception / return / interrupt events from
//             the CSR unit into one registered fetch redirect, generates the
//             acceptance pulses back to the CSR unit and escalates runs of
//             consecutive pipeline restarts into an exception.
//  Revision : 1.0 - initial release
// ============================================================================
module redirect_ctrl #(
   parameter int MAX_RST = 3,
   parameter int CW      = 4
) (
   input  wire logic       s_clk_i,
   input  wire logic       s_rst_i,
   redirect_ctrl_if.slave  rd
);

   localparam logic [0:0]    c_IDLE = 1'b0;
   localparam logic [0:0]    c_HOLD = 1'b1;
   localparam logic [CW-1:0] c_MAX  = CW'(MAX_RST);
   localparam logic [CW-1:0] c_ONE  = CW'(1);

   logic [0:0]    r_state;
   logic [0:0]    w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [31:0]   r_addr;
   logic [31:0]   w_target;

   logic w_sample;
   logic w_restart;
   logic w_exc;
   logic w_ret;
   logic w_int;
   logic w_any;
   logic w_escalate;
   logic w_interrupted;
   logic w_rstpp;
   logic w_hrdmax;

   // Events are only looked at in IDLE on a cycle MA actually advances;
   // reset suppresses sampling so the pulses stay low while it is held.
   assign w_sample   = (r_state == c_IDLE) & ~rd.s_stall_i & ~rd.s_flush_i & ~s_rst_i;
   assign w_restart  = w_sample & rd.s_valid_i & rd.s_rstpp_req_i;
   assign w_exc      = w_sample & rd.s_valid_i & rd.s_exception_i;
   assign w_ret      = w_sample & rd.s_valid_i & rd.s_treturn_i;
   assign w_int      = w_sample & rd.s_int_pending_i;
   assign w_any      = w_restart | w_exc | w_ret | w_int;
   assign w_escalate = w_restart & rd.s_hrdmax_en_i & (r_cnt == c_MAX);

   // State register.
   always_ff @(posedge s_clk_i) begin
      if (s_rst_i) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: enter HOLD on any accepted event, leave once fetch is ready.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: if (w_any) w_state_nxt = c_HOLD;
         c_HOLD: if (rd.s_fetch_ready_i) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Priority arbitration: target, acceptance pulses and next restart count.
   always_comb begin
      w_target      = r_addr;
      w_interrupted = 1'b0;
      w_rstpp       = 1'b0;
      w_hrdmax      = 1'b0;
      w_cnt_nxt     = r_cnt;
      if (w_restart) begin
         if (w_escalate) begin
            w_target  = rd.s_exc_trap_i;
            w_hrdmax  = 1'b1;
            w_cnt_nxt = '0;
         end else begin
            w_target  = rd.s_rst_point_i;
            w_rstpp   = 1'b1;
            // Saturate so a disabled limit can never wrap back to zero.
            w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + c_ONE;
         end
      end else if (w_exc) begin
         w_target  = rd.s_exc_trap_i;
         w_cnt_nxt = '0;
      end else if (w_ret) begin
         w_target  = rd.s_mepc_i;
         w_cnt_nxt = '0;
      end else if (w_int) begin
         w_target      = rd.s_int_trap_i;
         w_interrupted = 1'b1;
         w_cnt_nxt     = '0;
      end else if (w_sample & rd.s_valid_i) begin
         // A clean instruction completed: the restart streak is broken.
         w_cnt_nxt = '0;
      end
   end

   // Restart counter and captured redirect target.
   always_ff @(posedge s_clk_i) begin
      if (s_rst_i) begin
         r_cnt  <= '0;
         r_addr <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_any) begin
            r_addr <= w_target;
         end
      end
   end

   // Redirect valid is the HOLD state itself; everything is forced low in reset.
   assign rd.s_redirect_o     = (r_state == c_HOLD) & ~s_rst_i;
   assign rd.s_busy_o         = (r_state == c_HOLD) & ~s_rst_i;
   assign rd.s_redirect_add_o = s_rst_i ? 32'h0 : r_addr;
   assign rd.s_interrupted_o  = w_interrupted;
   assign rd.s_rstpp_o        = w_rstpp;
   assign rd.s_hrdmax_o       = w_hrdmax;

endmodule
`default_nettype wire

// File: tb/tb_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_redirect_ctrl
//  Brief    : Self-checking bench for redirect_ctrl: directed scenarios plus a
//             randomized run against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_redirect_ctrl;

   localparam int MAX_RST = 3;
   localparam int CW      = 4;
   localparam int SAT     = (1 << CW) - 1;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   redirect_ctrl_if bus ();

   redirect_ctrl #(.MAX_RST(MAX_RST), .CW(CW)) dut (
      .s_clk_i (clk),
      .s_rst_i (rst),
      .rd      (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // {redirect, busy, interrupted, rstpp, hrdmax}
   function automatic logic [4:0] obs();
      return {bus.s_redirect_o, bus.s_busy_o, bus.s_interrupted_o,
              bus.s_rstpp_o, bus.s_hrdmax_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.s_valid_i       = 1'b0;
      bus.s_stall_i       = 1'b0;
      bus.s_flush_i       = 1'b0;
      bus.s_rstpp_req_i   = 1'b0;
      bus.s_exception_i   = 1'b0;
      bus.s_treturn_i     = 1'b0;
      bus.s_int_pending_i = 1'b0;
      bus.s_fetch_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.s_valid_i = 1'b1; bus.s_exception_i = 1'b1;
      bus.s_rstpp_req_i = 1'b1; bus.s_int_pending_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++;
         if (obs() !== 5'b00000) begin
            n_err++; $display("FAIL reset_outs: got %b want %b", obs(), 5'b00000);
         end
         n_cmp++;
         if (bus.s_redirect_add_o !== 32'h0) begin
            n_err++; $display("FAIL reset_addr: got %h want %h", bus.s_redirect_add_o, 32'h0);
         end
         tick();
      end
      clear_in();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_exception();
      clear_in();
      bus.s_exc_trap_i = 32'h0000_0100;
      bus.s_valid_i = 1'b1; bus.s_exception_i = 1'b1; bus.s_fetch_ready_i = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== 5'b00000) begin
         n_err++; $display("FAIL exc_cycleN: got %b want %b", obs(), 5'b00000);
      end
      tick();
      clear_in(); bus.s_fetch_ready_i = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== 5'b11000 || bus.s_redirect_add_o !== 32'h100) begin
         n_err++; $display("FAIL exc_redirect: got %b/%h want %b/%h",
                           obs(), bus.s_redirect_add_o, 5'b11000, 32'h100);
      end
      tick();
      clear_in();
      #1;
      n_cmp++;
      if (obs() !== 5'b00000) begin
         n_err++; $display("FAIL exc_one_cycle: got %b want %b", obs(), 5'b00000);
      end
   endtask

   task automatic test_interrupt_hold();
      clear_in();
      bus.s_int_trap_i = 32'h0000_0204;
      bus.s_int_pending_i = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== 5'b00100) begin
         n_err++; $display("FAIL int_pulse: got %b want %b", obs(), 5'b00100);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         clear_in();
         bus.s_fetch_ready_i = (i == 3);
         bus.s_valid_i       = (i == 1);
         bus.s_exception_i   = (i == 1);
         #1;
         n_cmp++;
         if (obs() !== 5'b11000 || bus.s_redirect_add_o !== 32'h204) begin
            n_err++; $display("FAIL int_hold[%0d]: got %b/%h want %b/%h",
                              i, obs(), bus.s_redirect_add_o, 5'b11000, 32'h204);
         end
         tick();
      end
      clear_in();
      #1;
      n_cmp++;
      if (obs() !== 5'b00000) begin
         n_err++; $display("FAIL int_release: got %b want %b", obs(), 5'b00000);
      end
   endtask

   task automatic test_escalation();
      logic [4:0]  exp_p;
      logic [31:0] exp_a;
      clear_in();
      bus.s_valid_i = 1'b1;
      tick();
      bus.s_hrdmax_en_i = 1'b1;
      bus.s_rst_point_i = 32'h8000_0000;
      bus.s_exc_trap_i  = 32'h0000_0100;
      for (int k = 0; k < 5; k++) begin
         exp_p = (k == 3) ? 5'b00001 : 5'b00010;
         exp_a = (k == 3) ? 32'h0000_0100 : 32'h8000_0000;
         clear_in();
         bus.s_valid_i = 1'b1; bus.s_rstpp_req_i = 1'b1;
         #1;
         n_cmp++;
         if (obs() !== exp_p) begin
            n_err++; $display("FAIL esc_pulse[%0d]: got %b want %b", k, obs(), exp_p);
         end
         tick();
         clear_in(); bus.s_fetch_ready_i = 1'b1;
         #1;
         n_cmp++;
         if (obs() !== 5'b11000 || bus.s_redirect_add_o !== exp_a) begin
            n_err++; $display("FAIL esc_redirect[%0d]: got %b/%h want %b/%h",
                              k, obs(), bus.s_redirect_add_o, 5'b11000, exp_a);
         end
         tick();
      end
   endtask

   task automatic test_no_escalation();
      bit seq [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      bus.s_hrdmax_en_i = 1'b1;
      bus.s_rst_point_i = 32'h8000_0000;
      for (int k = 0; k < 7; k++) begin
         clear_in();
         bus.s_valid_i = 1'b1;
         bus.s_rstpp_req_i = seq[k];
         #1;
         n_cmp++;
         if (obs() !== (seq[k] ? 5'b00010 : 5'b00000)) begin
            n_err++; $display("FAIL noesc_pulse[%0d]: got %b want %b",
                              k, obs(), (seq[k] ? 5'b00010 : 5'b00000));
         end
         tick();
         if (seq[k]) begin
            clear_in(); bus.s_fetch_ready_i = 1'b1;
            #1;
            n_cmp++;
            if (obs() !== 5'b11000 || bus.s_redirect_add_o !== 32'h8000_0000) begin
               n_err++; $display("FAIL noesc_redirect[%0d]: got %b/%h want %b/%h",
                                 k, obs(), bus.s_redirect_add_o, 5'b11000, 32'h8000_0000);
            end
            tick();
         end
      end
   endtask

   task automatic test_priority();
      clear_in();
      bus.s_valid_i = 1'b1;
      tick();
      bus.s_rst_point_i = 32'h0000_1000;
      bus.s_exc_trap_i  = 32'h0000_2000;
      bus.s_int_trap_i  = 32'h0000_3000;
      bus.s_mepc_i      = 32'h0000_4000;
      bus.s_valid_i = 1'b1; bus.s_rstpp_req_i = 1'b1; bus.s_exception_i = 1'b1;
      bus.s_treturn_i = 1'b1; bus.s_int_pending_i = 1'b1; bus.s_fetch_ready_i = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== 5'b00010) begin
         n_err++; $display("FAIL prio_pulse: got %b want %b", obs(), 5'b00010);
      end
      tick();
      clear_in(); bus.s_fetch_ready_i = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== 5'b11000 || bus.s_redirect_add_o !== 32'h0000_1000) begin
         n_err++; $display("FAIL prio_redirect: got %b/%h want %b/%h",
                           obs(), bus.s_redirect_add_o, 5'b11000, 32'h0000_1000);
      end
      tick();
   endtask

   task automatic test_reset_in_hold_and_flush();
      clear_in();
      bus.s_valid_i = 1'b1;
      tick();
      bus.s_hrdmax_en_i = 1'b1;
      bus.s_rst_point_i = 32'h0000_5000;
      bus.s_rstpp_req_i = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== 5'b00010) begin
         n_err++; $display("FAIL rsthold_pulse: got %b want %b", obs(), 5'b00010);
      end
      tick();
      clear_in();
      #1;
      n_cmp++;
      if (obs() !== 5'b11000) begin
         n_err++; $display("FAIL rsthold_hold: got %b want %b", obs(), 5'b11000);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== 5'b00000 || bus.s_redirect_add_o !== 32'h0) begin
         n_err++; $display("FAIL rsthold_during: got %b/%h want %b/%h",
                           obs(), bus.s_redirect_add_o, 5'b00000, 32'h0);
      end
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (obs() !== 5'b00000) begin
         n_err++; $display("FAIL rsthold_after: got %b want %b", obs(), 5'b00000);
      end
      // A surviving count would escalate on the third restart below.
      for (int k = 0; k < 3; k++) begin
         clear_in();
         bus.s_valid_i = 1'b1; bus.s_rstpp_req_i = 1'b1;
         #1;
         n_cmp++;
         if (obs() !== 5'b00010) begin
            n_err++; $display("FAIL rsthold_cnt[%0d]: got %b want %b", k, obs(), 5'b00010);
         end
         tick();
         clear_in(); bus.s_fetch_ready_i = 1'b1;
         tick();
      end
      clear_in();
      bus.s_valid_i = 1'b1; bus.s_exception_i = 1'b1;
      bus.s_int_pending_i = 1'b1; bus.s_flush_i = 1'b1;
      #1;
      n_cmp++;
      if (obs() !== 5'b00000) begin
         n_err++; $display("FAIL flush_pulse: got %b want %b", obs(), 5'b00000);
      end
      tick();
      clear_in();
      #1;
      n_cmp++;
      if (obs() !== 5'b00000) begin
         n_err++; $display("FAIL flush_noredirect: got %b want %b", obs(), 5'b00000);
      end
   endtask

   task automatic test_random();
      bit          m_busy;
      logic [31:0] m_tgt;
      int          m_streak;
      logic [4:0]  exp_o;
      bit          nb;
      logic [31:0] nt;
      int          ns;
      m_busy = 1'b0; m_tgt = 32'h0; m_streak = 0;
      for (int i = 0; i < 3000; i++) begin
         rst                 = (i == 0) || ($urandom_range(0, 99) < 2);
         bus.s_valid_i       = ($urandom_range(0, 99) < 75);
         bus.s_stall_i       = ($urandom_range(0, 99) < 15);
         bus.s_flush_i       = ($urandom_range(0, 99) < 10);
         bus.s_rstpp_req_i   = ($urandom_range(0, 99) < 50);
         bus.s_exception_i   = ($urandom_range(0, 99) < 15);
         bus.s_treturn_i     = ($urandom_range(0, 99) < 15);
         bus.s_int_pending_i = ($urandom_range(0, 99) < 15);
         bus.s_hrdmax_en_i   = ($urandom_range(0, 99) < 80);
         bus.s_fetch_ready_i = ($urandom_range(0, 99) < 50);
         bus.s_rst_point_i   = $urandom;
         bus.s_exc_trap_i    = $urandom;
         bus.s_int_trap_i    = $urandom;
         bus.s_mepc_i        = $urandom;
         #1;
         exp_o = 5'b00000;
         nb = m_busy; nt = m_tgt; ns = m_streak;
         if (rst) begin
            nb = 1'b0; ns = 0; nt = 32'h0;
         end else if (m_busy) begin
            exp_o = 5'b11000;
            if (bus.s_fetch_ready_i) nb = 1'b0;
         end else if (!bus.s_stall_i && !bus.s_flush_i) begin
            if (bus.s_valid_i && bus.s_rstpp_req_i) begin
               nb = 1'b1;
               if (bus.s_hrdmax_en_i && m_streak == MAX_RST) begin
                  exp_o = 5'b00001; nt = bus.s_exc_trap_i; ns = 0;
               end else begin
                  exp_o = 5'b00010; nt = bus.s_rst_point_i;
                  ns = (m_streak < SAT) ? m_streak + 1 : SAT;
               end
            end else if (bus.s_valid_i && bus.s_exception_i) begin
               nb = 1'b1; nt = bus.s_exc_trap_i; ns = 0;
            end else if (bus.s_valid_i && bus.s_treturn_i) begin
               nb = 1'b1; nt = bus.s_mepc_i; ns = 0;
            end else if (bus.s_int_pending_i) begin
               nb = 1'b1; nt = bus.s_int_trap_i; ns = 0; exp_o = 5'b00100;
            end else if (bus.s_valid_i) begin
               ns = 0;
            end
         end
         n_cmp++;
         if (obs() !== exp_o) begin
            n_err++; $display("FAIL rand_outs[%0d]: got %b want %b", i, obs(), exp_o);
         end
         if (rst || m_busy) begin
            n_cmp++;
            if (bus.s_redirect_add_o !== (rst ? 32'h0 : m_tgt)) begin
               n_err++; $display("FAIL rand_addr[%0d]: got %h want %h",
                                 i, bus.s_redirect_add_o, (rst ? 32'h0 : m_tgt));
            end
         end
         m_busy = nb; m_tgt = nt; m_streak = ns;
         tick();
      end
      rst = 1'b0;
      clear_in();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      clear_in();
      bus.s_hrdmax_en_i = 1'b0;
      bus.s_rst_point_i = 32'h0;
      bus.s_exc_trap_i  = 32'h0;
      bus.s_int_trap_i  = 32'h0;
      bus.s_mepc_i      = 32'h0;
      tick();
      tick();
      test_reset();
      test_exception();
      test_interrupt_hold();
      test_escalation();
      test_no_escalation();
      test_priority();
      test_reset_in_hold_and_flush();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
